// File: rtl/svi_rr_arbiter.sv
// svi_rr_arbiter: two-producer round-robin owner of the shared y bus, with the en capture strobe.
// An owner is forced to yield after HOLD_MAX beats, but only when the other side is waiting.
module svi_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic [1:0]       i_req,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic             i_busy,
    output logic [1:0]       o_gnt,
    output logic [WIDTH-1:0] o_y,
    output logic             o_en
);
    localparam int CW = $clog2(HOLD_MAX + 1);

    // State encoding doubles as the one-hot grant.
    typedef enum logic [1:0] {IDLE = 2'b00, OWN_A = 2'b01, OWN_B = 2'b10} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             en_q, en_d;
    logic             owning, own, mine, other, at_max, rel, beat;

    assign owning = state_q != IDLE;
    assign own    = state_q == OWN_B;
    assign mine   = i_req[own];
    assign other  = i_req[~own];
    assign at_max = cnt_q == CW'(HOLD_MAX);
    assign rel    = owning && (!mine || (at_max && other));
    // A releasing cycle never carries a beat, including the forced rotation.
    assign beat   = owning && mine && !i_busy && !rel;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            y_q     <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            y_q     <= y_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = !owning ? ((i_req == 2'b11) ? (last_q ? OWN_A : OWN_B) :
                             i_req[0] ? OWN_A : i_req[1] ? OWN_B : IDLE) :
                  rel ? (other ? (own ? OWN_A : OWN_B) : IDLE) : state_q;
        last_d  = rel ? own : last_q;
        cnt_d   = rel ? '0 : (beat && !at_max) ? cnt_q + CW'(1) : cnt_q;
    end

    always_comb begin
        y_d   = beat ? (own ? i_data_b : i_data_a) : y_q;
        en_d  = beat;
        o_gnt = state_q;
        o_y   = y_q;
        o_en  = en_q;
    end
endmodule

// File: tb/tb_svi_rr_arbiter.sv
// tb_svi_rr_arbiter: directed vectors; expected beats are queued by the driver and checked by a monitor.
module tb_svi_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = '0;
    logic [7:0] da = '0, db = '0;
    logic       busy = 1'b0;
    logic [1:0] gnt;
    logic [7:0] y;
    logic       en;
    int         n_cmp = 0, n_err = 0;
    logic [9:0] sb[$];
    logic [9:0] mon_e;

    always #5 clk = ~clk;

    svi_rr_arbiter #(.WIDTH(8), .HOLD_MAX(4)) dut (
        .i_clk(clk), .i_arst(rst), .i_req(req), .i_data_a(da), .i_data_b(db),
        .i_busy(busy), .o_gnt(gnt), .o_y(y), .o_en(en)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [1:0] r, input logic [7:0] a, input logic [7:0] b, input logic bz);
        req = r; da = a; db = b; busy = bz;
    endtask

    task automatic step(input logic [1:0] r, input logic [7:0] a, input logic [7:0] b, input logic bz);
        drv(r, a, b, bz);
        @(negedge clk);
    endtask

    // Vector that must produce a beat: queue its owner and data, then apply it.
    task automatic beat(input logic [1:0] r, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] g, input logic [7:0] d);
        sb.push_back({g, d});
        step(r, a, b, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && en) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL beat: unexpected strobe gnt=%b y=%h, none expected", gnt, y);
            end else begin
                mon_e = sb.pop_front();
                if ({gnt, y} !== mon_e) begin
                    n_err++;
                    $display("FAIL beat: got gnt=%b y=%h expected gnt=%b y=%h",
                             gnt, y, mon_e[9:8], mon_e[7:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        drv(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        #12;
        chk("reset gnt", 8'(gnt), 8'h00);
        chk("reset y", y, 8'h00);
        chk("reset en", 8'(en), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        drv(2'b00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle gnt", 8'(gnt), 8'h00);
            chk("idle en", 8'(en), 8'h00);
            chk("idle y", y, 8'h00);
        end
        // Lone requester A: grant, then beats beyond HOLD_MAX without losing ownership.
        step(2'b01, 8'h11, 8'h00, 1'b0);
        chk("grant A", 8'(gnt), 8'h01);
        chk("grant no strobe", 8'(en), 8'h00);
        beat(2'b01, 8'h11, 8'h00, 2'b01, 8'h11);
        beat(2'b01, 8'h12, 8'h00, 2'b01, 8'h12);
        beat(2'b01, 8'h13, 8'h00, 2'b01, 8'h13);
        beat(2'b01, 8'h14, 8'h00, 2'b01, 8'h14);
        beat(2'b01, 8'h15, 8'h00, 2'b01, 8'h15);
        beat(2'b01, 8'h16, 8'h00, 2'b01, 8'h16);
        chk("A keeps past hold", 8'(gnt), 8'h01);
        step(2'b00, 8'h00, 8'h00, 1'b0);
        chk("A release to idle", 8'(gnt), 8'h00);
        chk("release no strobe", 8'(en), 8'h00);
        // Last owner was A, so B wins a tie; then voluntary handoffs both ways.
        step(2'b11, 8'h51, 8'h41, 1'b0);
        chk("tie goes to B", 8'(gnt), 8'h02);
        beat(2'b11, 8'h51, 8'h41, 2'b10, 8'h41);
        beat(2'b11, 8'h51, 8'h42, 2'b10, 8'h42);
        step(2'b01, 8'h51, 8'h00, 1'b0);
        chk("handoff B to A", 8'(gnt), 8'h01);
        chk("handoff no strobe", 8'(en), 8'h00);
        beat(2'b01, 8'h51, 8'h00, 2'b01, 8'h51);
        beat(2'b11, 8'h52, 8'h43, 2'b01, 8'h52);
        step(2'b10, 8'h00, 8'h43, 1'b0);
        chk("handoff A to B", 8'(gnt), 8'h02);
        beat(2'b10, 8'h00, 8'h43, 2'b10, 8'h43);
        step(2'b00, 8'h00, 8'h00, 1'b0);
        chk("B release to idle", 8'(gnt), 8'h00);
        // Last owner was B, so A wins; stall must not advance the hold count.
        step(2'b11, 8'h11, 8'h71, 1'b0);
        chk("tie goes to A", 8'(gnt), 8'h01);
        beat(2'b11, 8'h11, 8'h71, 2'b01, 8'h11);
        beat(2'b11, 8'h12, 8'h71, 2'b01, 8'h12);
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 8'h13, 8'h71, 1'b1);
            chk("stall en", 8'(en), 8'h00);
            chk("stall y hold", y, 8'h12);
            chk("stall gnt", 8'(gnt), 8'h01);
        end
        beat(2'b11, 8'h13, 8'h71, 2'b01, 8'h13);
        beat(2'b11, 8'h14, 8'h71, 2'b01, 8'h14);
        step(2'b11, 8'h15, 8'h71, 1'b0);
        chk("rotate to B", 8'(gnt), 8'h02);
        chk("rotate no strobe", 8'(en), 8'h00);
        chk("rotate y hold", y, 8'h14);
        beat(2'b11, 8'h15, 8'h71, 2'b10, 8'h71);
        beat(2'b11, 8'h15, 8'h72, 2'b10, 8'h72);
        beat(2'b11, 8'h15, 8'h73, 2'b10, 8'h73);
        beat(2'b11, 8'h15, 8'h74, 2'b10, 8'h74);
        step(2'b11, 8'h15, 8'h75, 1'b0);
        chk("rotate to A", 8'(gnt), 8'h01);
        chk("rotate A no strobe", 8'(en), 8'h00);
        beat(2'b11, 8'h15, 8'h75, 2'b01, 8'h15);
        beat(2'b11, 8'h16, 8'h75, 2'b01, 8'h16);
        beat(2'b11, 8'h17, 8'h75, 2'b01, 8'h17);
        beat(2'b11, 8'h18, 8'h75, 2'b01, 8'h18);
        step(2'b11, 8'h19, 8'h75, 1'b0);
        chk("rotate to B again", 8'(gnt), 8'h02);
        beat(2'b11, 8'h19, 8'h75, 2'b10, 8'h75);
        beat(2'b11, 8'h19, 8'h76, 2'b10, 8'h76);
        // Reset lands while B's third beat is being presented; it must be dropped.
        drv(2'b11, 8'h19, 8'h77, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async reset en", 8'(en), 8'h00);
        chk("async reset y", y, 8'h00);
        chk("async reset gnt", 8'(gnt), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(2'b11, 8'h21, 8'h81, 1'b0);
        chk("A first after reset", 8'(gnt), 8'h01);
        chk("post reset y", y, 8'h00);
        beat(2'b11, 8'h21, 8'h81, 2'b01, 8'h21);
        step(2'b00, 8'h00, 8'h00, 1'b0);
        step(2'b00, 8'h00, 8'h00, 1'b0);
        chk("final idle", 8'(gnt), 8'h00);
        chk("scoreboard drained", 8'(sb.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
